sprite_rom_arbiter: RTL and testbench

Shares the single-port sprite ROM between several pixel/sprite requesters, such as the colour mapper's shape fetch, the player sprite prefetcher and the enemy sprite prefetchers.
Each requester asks for a burst of consecutive ROM words. The block grants requesters in round-robin order, drives the ROM address, tracks the ROM read latency and routes each returned word to the requester that asked for it.
It sits between the sprite/row-buffer logic and single_port_rom, in the VGA pixel clock domain.

---
 rtl/sprite_rom_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/sprite_rom_arbiter.sv | 140 ++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_rom_pkg.sv
// rtl/sprite_rom_pkg.sv - shared defaults, FSM state and return-tag types for the sprite ROM arbiter
package sprite_rom_pkg;

    localparam int NUM_REQ_DFLT = 4;
    localparam int ADDR_W_DFLT  = 15;
    localparam int DATA_W_DFLT  = 32;
    localparam int LEN_W_DFLT   = 5;
    localparam int MAX_REQ      = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // id is sized for the largest supported requester count; an all-zero id means no word
    typedef struct packed {
        logic [MAX_REQ-1:0] id;
        logic               last;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick with optional absolute priority for requester 0
module rr_arbiter
    import sprite_rom_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DFLT,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               prio0_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   jj;
    logic               found;
    int                 j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = req;
        jj    = '0;
        j     = 0;
        if (prio0_en && req[0]) begin
            found = 1'b1;
        end else begin
            // with priority enabled requester 0 never takes part in the rotation
            if (prio0_en) begin
                cand[0] = 1'b0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                j = int'(ptr) + i;
                if (j >= NUM_REQ) begin
                    j = j - NUM_REQ;
                end
                jj = IDX_W'(j);
                if (!found && cand[jj]) begin
                    found = 1'b1;
                    idx   = jj;
                end
            end
        end
        if (found) begin
            grant[idx] = 1'b1;
        end
        any = found;
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - burst arbiter for the shared sprite ROM; FIXED_PRIO0_EN gives requester 0 absolute priority
module sprite_rom_arbiter
    import sprite_rom_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DFLT,
    parameter int ADDR_W  = ADDR_W_DFLT,
    parameter int DATA_W  = DATA_W_DFLT,
    parameter int ROM_LAT = 1,
    parameter int LEN_W   = LEN_W_DFLT
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      busy,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic                      rd_last,
    output logic [DATA_W-1:0]         rd_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef FIXED_PRIO0_EN
    localparam logic PRIO0 = 1'b1;
`else
    localparam logic PRIO0 = 1'b0;
`endif

    arb_state_t          state, state_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [LEN_W-1:0]    remaining, remaining_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [NUM_REQ-1:0]  owner;
    tag_t                issue_tag;
    tag_t                tag_pipe [ROM_LAT+1];
    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LEN_W-1:0]    sel_len;
    logic                tag_unused;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req      (req),
        .ptr      (ptr),
        .prio0_en (PRIO0),
        .grant    (arb_grant),
        .idx      (arb_idx),
        .any      (arb_any)
    );

    assign sel_addr = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
    assign sel_len  = req_len[int'(arb_idx)*LEN_W +: LEN_W];
    assign busy     = (state == BURST);

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        remaining_nxt = remaining;
        addr_nxt      = rom_addr;
        issue_tag     = '0;
        gnt           = '0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    gnt            = arb_grant;
                    addr_nxt       = sel_addr;
                    remaining_nxt  = (sel_len == '0) ? '0 : sel_len - LEN_W'(1);
                    issue_tag.id   = MAX_REQ'(arb_grant);
                    issue_tag.last = (sel_len <= LEN_W'(1));
                    if (sel_len > LEN_W'(1)) begin
                        state_nxt = BURST;
                    end
                    // a priority win by requester 0 leaves the rotation among the others untouched
                    if (!(PRIO0 && arb_idx == '0)) begin
                        if (int'(arb_idx) == NUM_REQ - 1) begin
                            ptr_nxt = PRIO0 ? IDX_W'(1) : '0;
                        end else begin
                            ptr_nxt = arb_idx + IDX_W'(1);
                        end
                    end
                end
            end
            BURST: begin
                addr_nxt       = rom_addr + ADDR_W'(1);
                remaining_nxt  = remaining - LEN_W'(1);
                issue_tag.id   = MAX_REQ'(owner);
                issue_tag.last = (remaining == LEN_W'(1));
                if (remaining == LEN_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!Reset) begin
            gnt = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            owner     <= '0;
            rom_addr  <= '0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_pipe[k] <= '0;
            end
            rd_valid  <= '0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            remaining <= remaining_nxt;
            rom_addr  <= addr_nxt;
            if (state == IDLE && arb_any) begin
                owner <= arb_grant;
            end
            // stage 0 travels with rom_addr; the final stage lines up with rom_data
            tag_pipe[0] <= issue_tag;
            for (int k = 1; k <= ROM_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
            rd_valid <= tag_pipe[ROM_LAT].id[NUM_REQ-1:0];
            rd_last  <= tag_pipe[ROM_LAT].last;
            rd_data  <= rom_data;
        end
    end

    assign tag_unused = ^tag_pipe[ROM_LAT].id;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - scoreboard bench for sprite_rom_arbiter with a one-cycle-latency ROM model
module tb_sprite_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int LW = 5;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    gnt;
    logic            busy;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic [N-1:0]    rd_valid;
    logic            rd_last;
    logic [DW-1:0]   rd_data;

    typedef struct {
        int            cyc;
        logic [N-1:0]  id;
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic [AW-1:0] wrap_tab [4];

    always #5 clk = ~clk;

    sprite_rom_arbiter dut (
        .Clk      (clk),
        .Reset    (resetn),
        .req      (req),
        .req_addr (req_addr),
        .req_len  (req_len),
        .gnt      (gnt),
        .busy     (busy),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rd_valid (rd_valid),
        .rd_last  (rd_last),
        .rd_data  (rd_data)
    );

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {2'b10, a, ~a};
    endfunction

    always @(posedge clk) rom_data <= rom_word(rom_addr);
    always @(posedge clk) cyc <= cyc + 1;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req[i] = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_len[i*LW +: LW] = l;
    endtask

    task automatic push_burst(input int gcyc, input int idx, input logic [AW-1:0] a, input int len);
        exp_t e;
        int n;
        n = (len == 0) ? 1 : len;
        for (int k = 0; k < n; k++) begin
            e.cyc  = gcyc + 3 + k;
            e.id   = N'(1) << idx;
            e.last = (k == n - 1);
            e.data = rom_word(a + AW'(k));
            sbq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid !== '0) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got id=%b last=%b data=%h at cycle %0d, required no word",
                         rd_valid, rd_last, rd_data, cyc);
            end else begin
                mon_e = sbq.pop_front();
                if (cyc != mon_e.cyc || rd_valid !== mon_e.id || rd_last !== mon_e.last || rd_data !== mon_e.data) begin
                    n_err++;
                    $display("FAIL rd_word: got cyc=%0d id=%b last=%b data=%h, required cyc=%0d id=%b last=%b data=%h",
                             cyc, rd_valid, rd_last, rd_data, mon_e.cyc, mon_e.id, mon_e.last, mon_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1);
    end

    initial begin
        wrap_tab[0] = 15'h7FFE;
        wrap_tab[1] = 15'h7FFF;
        wrap_tab[2] = 15'h0000;
        wrap_tab[3] = 15'h0001;
        req = '0;
        req_addr = '0;
        req_len = '0;

        // reset state; a request during reset must not be granted
        nxt();
        set_req(0, 15'h0000, 5'd1);
        smp();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_rom_addr", 32'(rom_addr), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_rd_valid", 32'(rd_valid), 32'h0);
        chk("reset_rd_last", 32'(rd_last), 32'h0);
        chk("reset_rd_data", rd_data, 32'h0);
        nxt();
        req = '0;
        resetn = 1'b1;
        nxt();

`ifdef FIXED_PRIO0_EN
        for (int i = 0; i < 3; i++) set_req(i, AW'(15'h0200 + i), 5'd1);
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("prio0_gnt", 32'(gnt), 32'h1);
            push_burst(cyc, 0, 15'h0200, 1);
            nxt();
        end
        req[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("prio_rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'h2 : 32'h4);
            push_burst(cyc, (k % 2 == 0) ? 1 : 2, AW'(15'h0200 + ((k % 2 == 0) ? 1 : 2)), 1);
            nxt();
        end
        req = '0;
`else
        for (int i = 0; i < N; i++) set_req(i, AW'(15'h0200 + i), 5'd1);
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("rr_gnt", 32'(gnt), 32'h1 << (k % N));
            push_burst(cyc, k % N, AW'(15'h0200 + (k % N)), 1);
            nxt();
        end
        req = '0;
`endif
        nxt();
        nxt();

        // single word
        set_req(2, 15'h0010, 5'd1);
        smp();
        chk("single_gnt", 32'(gnt), 32'h4);
        push_burst(cyc, 2, 15'h0010, 1);
        nxt();
        req = '0;
        smp();
        chk("single_rom_addr", 32'(rom_addr), 32'h0010);
        nxt();

        // burst across the top of the address space
        set_req(0, 15'h7FFE, 5'd4);
        smp();
        chk("wrap_gnt", 32'(gnt), 32'h1);
        push_burst(cyc, 0, 15'h7FFE, 4);
        nxt();
        req = '0;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("wrap_rom_addr", 32'(rom_addr), 32'(wrap_tab[k]));
            chk("wrap_busy", 32'(busy), (k < 3) ? 32'h1 : 32'h0);
            nxt();
        end
        repeat (4) nxt();

        // reset in the middle of a burst: nothing issued may come back
        set_req(1, 15'h0100, 5'd8);
        smp();
        chk("abort_gnt", 32'(gnt), 32'h2);
        nxt();
        req = '0;
        nxt();
        resetn = 1'b0;
        nxt();
        resetn = 1'b1;
        smp();
        chk("abort_rom_addr", 32'(rom_addr), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_rd_valid", 32'(rd_valid), 32'h0);
        chk("abort_rd_last", 32'(rd_last), 32'h0);
        chk("abort_rd_data", rd_data, 32'h0);
        nxt();

        // length 0 against a 2-word burst with the pointer at 0
        set_req(3, 15'h0300, 5'd0);
        set_req(1, 15'h0120, 5'd2);
        smp();
        chk("len0_first_gnt", 32'(gnt), 32'h2);
        push_burst(cyc, 1, 15'h0120, 2);
        nxt();
        req[1] = 1'b0;
        smp();
        chk("len0_burst_gnt", 32'(gnt), 32'h0);
        chk("len0_burst_busy", 32'(busy), 32'h1);
        nxt();
        smp();
        chk("len0_second_gnt", 32'(gnt), 32'h8);
        push_burst(cyc, 3, 15'h0300, 0);
        nxt();
        req = '0;

        repeat (8) nxt();
        chk("sb_drained", 32'(sbq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
